pcie_tx_scheduler: RTL
======================

PCIE_TX_SCHEDULER -- requirements
Module: pcie_tx_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning DLLP AXIS data width.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, meaning tkeep width.
REQ-003 SHALL have parameter USER_WIDTH, default 5, meaning tuser width.
REQ-004 SHALL have parameter SKP_INTERVAL, default 1180, meaning clk_i cycles between SKP ordered set schedules; legal range 16..65535.
REQ-005 SHALL have ports, one clock, asynchronous active-low reset: clk_i in 1 clock; rst_ni in 1 async active-low reset.
REQ-006 SHALL have ports: link_up_i in 1 LTSSM link-up; os_req_i in 1 LTSSM ordered-set request, level, held until os_gnt_o.
REQ-007 SHALL have ports: os_gnt_o out 1 one-cycle pulse, LTSSM ordered set done; send_ordered_set_o out 1 ordered-set request to transmitter; os_skp_sel_o out 1 (1=SKP, 0=LTSSM set).
REQ-008 SHALL have ports: ordered_set_tranmitted_i in 1 transmitter completion pulse; skp_pending_o out 2 pending SKP count; state_o out 2 FSM state encoding.
REQ-009 SHALL have ports: s_dllp_axis_tdata/tkeep/tvalid/tlast/tuser in, tready out (DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH/1); m_dllp_axis_* mirrored toward transmitter.

Function
REQ-010 SHALL implement FSM states IDLE=0, DLLP=1, OS_LTSSM=2, OS_SKP=3, driven on state_o.
REQ-011 IDLE priority, evaluated each cycle: skp_pending>0 and link_up_i -> OS_SKP; else os_req_i -> OS_LTSSM; else link_up_i and s_dllp_axis_tvalid -> DLLP.
REQ-012 DLLP: m_dllp_axis_* = s_dllp_axis_* combinationally, s tready = m tready; on beat with tvalid&tready&tlast -> IDLE; packets never interrupted by SKP or LTSSM requests.
REQ-013 Outside DLLP state: m_dllp_axis_tvalid=0, s_dllp_axis_tready=0; grant latency from IDLE is one cycle.
REQ-014 OS states: send_ordered_set_o=1 for every cycle in state; os_skp_sel_o=1 in OS_SKP, 0 otherwise; on ordered_set_tranmitted_i -> IDLE next cycle.
REQ-015 OS_LTSSM exit SHALL pulse os_gnt_o for exactly one cycle; OS_SKP exit SHALL decrement skp_pending.
REQ-016 SKP timer counts 0..SKP_INTERVAL-1 while link_up_i, wraps to 0; wrap increments skp_pending, saturating at 2.
REQ-017 Simultaneous wrap and SKP completion: pending unchanged; wrap at pending=2: stays 2.
REQ-018 link_up_i low: timer and skp_pending cleared to 0; DLLP or OS_SKP state aborts to IDLE next cycle (truncated packet accepted behaviour); OS_LTSSM unaffected.
REQ-019 ordered_set_tranmitted_i outside OS states SHALL be ignored.

Reset
REQ-020 rst_ni low asynchronously: state IDLE, timer 0, skp_pending 0, os_gnt_o 0, send_ordered_set_o 0, os_skp_sel_o 0, m tvalid 0, s tready 0.
REQ-021 Deassertion synchronous to clk_i via two-stage synchronizer inside block; first transition earliest on second rising edge after release.

Configuration
REQ-022 Macro PCIE_TX_SKP_SCHED_EN defined: SKP timer, pending counter and OS_SKP state present per REQ-016..018.
REQ-023 Macro undefined: no timer logic, skp_pending_o=0, os_skp_sel_o=0, OS_SKP unreachable; other behaviour identical.

Structure
REQ-024 State enum tx_sched_state_e and SKP_PENDING_MAX=2 SHALL live in pcie_phy_pkg.
REQ-025 Timer+saturating pending counter SHALL be sub-module pcie_skp_timer.

Verification
REQ-026 link_up=1, SKP_INTERVAL=16, idle bus -> send_ordered_set_o with os_skp_sel_o=1 in cycle after 16th timer cycle; completion pulse -> pending 1->0.
REQ-027 5-beat DLLP packet in flight, timer wraps at beat 2 -> all 5 beats pass, OS_SKP entered the cycle after tlast beat.
REQ-028 os_req_i and s tvalid both high in IDLE, pending 0 -> OS_LTSSM, tready=0 until os_gnt_o pulse, then DLLP.
REQ-029 Transmitter stalled 40 cycles in OS_LTSSM, SKP_INTERVAL=16 -> pending saturates at 2, two SKP sets follow back-to-back.
REQ-030 link_up_i drops mid-packet and rst_ni asserted mid-OS_SKP -> IDLE, pending 0, all outputs at REQ-020 values.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// ============================================================================
// Module      : pcie_phy_pkg
// Description : Shared types and constants for the PCIe PHY transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcie_phy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DLLP     = 2'd1,
    ST_OS_LTSSM = 2'd2,
    ST_OS_SKP   = 2'd3
  } tx_sched_state_e;

  localparam int unsigned SKP_PENDING_MAX = 2;
  localparam int unsigned SKP_CNT_W       = 16;

endpackage

`default_nettype wire

// File: rtl/pcie_skp_timer.sv
// ============================================================================
// Module      : pcie_skp_timer
// Description : Free-running SKP interval timer with saturating pending count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_skp_timer #(
  parameter int unsigned SKP_INTERVAL = 1180
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       link_up_i,
  input  logic       skp_done_i,
  output logic [1:0] skp_pending_o
);
  import pcie_phy_pkg::*;

  localparam logic [SKP_CNT_W-1:0] CNT_LAST = SKP_CNT_W'(SKP_INTERVAL - 1);
  localparam logic [1:0]           PEND_MAX = 2'(SKP_PENDING_MAX);

  logic [SKP_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           pend_q, pend_d;
  logic                 wrap;

  // A wrap and a completion in the same cycle cancel each other out.
  always_comb begin
    wrap   = link_up_i && (cnt_q == CNT_LAST);
    cnt_d  = '0;
    pend_d = '0;
    if (link_up_i) begin
      cnt_d  = wrap ? '0 : cnt_q + 1'b1;
      pend_d = pend_q;
      if (wrap && !skp_done_i && (pend_q != PEND_MAX)) begin
        pend_d = pend_q + 2'd1;
      end else if (skp_done_i && !wrap && (pend_q != 2'd0)) begin
        pend_d = pend_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign skp_pending_o = pend_q;

endmodule

`default_nettype wire

// File: rtl/pcie_tx_scheduler.sv
// ============================================================================
// Module      : pcie_tx_scheduler
// Description : Arbitrates DLLP packets, LTSSM ordered sets and periodic SKP
//               ordered sets onto the PCIe transmitter. SKP scheduling is
//               built only when PCIE_TX_SKP_SCHED_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_tx_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 5,
  parameter int SKP_INTERVAL = 1180
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  link_up_i,
  input  logic                  os_req_i,
  output logic                  os_gnt_o,
  output logic                  send_ordered_set_o,
  output logic                  os_skp_sel_o,
  input  logic                  ordered_set_tranmitted_i,
  output logic [1:0]            skp_pending_o,
  output logic [1:0]            state_o,
  input  logic [DATA_WIDTH-1:0] s_dllp_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_dllp_axis_tkeep,
  input  logic                  s_dllp_axis_tvalid,
  input  logic                  s_dllp_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_dllp_axis_tuser,
  output logic                  s_dllp_axis_tready,
  output logic [DATA_WIDTH-1:0] m_dllp_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_dllp_axis_tkeep,
  output logic                  m_dllp_axis_tvalid,
  output logic                  m_dllp_axis_tlast,
  output logic [USER_WIDTH-1:0] m_dllp_axis_tuser,
  input  logic                  m_dllp_axis_tready
);
  import pcie_phy_pkg::*;

  if (SKP_INTERVAL < 16 || SKP_INTERVAL > 65535) begin : g_bad_skp_interval
    $error("pcie_tx_scheduler: SKP_INTERVAL must be within 16..65535");
  end

  tx_sched_state_e state_q, state_d;
  logic [1:0]      rst_sync_q;
  logic            rst_int_n;
  logic [1:0]      skp_pending;
  logic            in_dllp;

  // Assert asynchronously, release two edges after rst_ni rises.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

`ifdef PCIE_TX_SKP_SCHED_EN
  logic skp_done;
  assign skp_done = (state_q == ST_OS_SKP) && ordered_set_tranmitted_i;

  pcie_skp_timer #(
    .SKP_INTERVAL (SKP_INTERVAL)
  ) u_skp_timer (
    .clk_i         (clk_i),
    .rst_ni        (rst_int_n),
    .link_up_i     (link_up_i),
    .skp_done_i    (skp_done),
    .skp_pending_o (skp_pending)
  );
`else
  assign skp_pending = 2'd0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if ((skp_pending != 2'd0) && link_up_i)       state_d = ST_OS_SKP;
        else if (os_req_i)                            state_d = ST_OS_LTSSM;
        else if (link_up_i && s_dllp_axis_tvalid)     state_d = ST_DLLP;
      end
      // A packet only ends on its last beat or when the link goes away.
      ST_DLLP: begin
        if (!link_up_i ||
            (s_dllp_axis_tvalid && m_dllp_axis_tready && s_dllp_axis_tlast))
          state_d = ST_IDLE;
      end
      ST_OS_LTSSM: if (ordered_set_tranmitted_i)              state_d = ST_IDLE;
      ST_OS_SKP:   if (!link_up_i || ordered_set_tranmitted_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  assign in_dllp            = (state_q == ST_DLLP);
  assign state_o            = state_q;
  assign skp_pending_o      = skp_pending;
  assign send_ordered_set_o = (state_q == ST_OS_LTSSM) || (state_q == ST_OS_SKP);
  assign os_skp_sel_o       = (state_q == ST_OS_SKP);
  assign os_gnt_o           = (state_q == ST_OS_LTSSM) && ordered_set_tranmitted_i;

  assign m_dllp_axis_tdata  = s_dllp_axis_tdata;
  assign m_dllp_axis_tkeep  = s_dllp_axis_tkeep;
  assign m_dllp_axis_tlast  = s_dllp_axis_tlast;
  assign m_dllp_axis_tuser  = s_dllp_axis_tuser;
  assign m_dllp_axis_tvalid = in_dllp && s_dllp_axis_tvalid;
  assign s_dllp_axis_tready = in_dllp && m_dllp_axis_tready;

endmodule

`default_nettype wire
